// File: rtl/pipe_debug_controller.sv
// ---------------------------------------------------------------------------
// pipe_debug_controller
//
// Debug controller sitting between the UART and the pipeline registers.
// Pops command bytes from the UART RX FIFO, decodes them into a single
// step, a continuous run until end-of-program, or a pipeline reset, gates
// the pipeline clock enable accordingly, and after a step/run serialises a
// NUM_WORDS x WORD_BYTES snapshot of pipeline state into the UART TX FIFO,
// one byte at a time, waiting for each byte to be transmitted.
//
// Ports
//   clock         system clock
//   reset         asynchronous, active-high reset
//   rx_data       head byte of the RX FIFO, valid the cycle after rx_read
//   rx_available  RX FIFO is non-empty
//   rx_read       one-cycle pop strobe for the RX FIFO
//   tx_data       byte presented to the TX FIFO
//   tx_write      one-cycle push strobe for tx_data
//   tx_done       one-cycle pulse: previously pushed byte has been sent
//   eop           end-of-program flag from the WB stage
//   snapshot      flat pipeline/register state, word 0 in the LSBs
//   pipe_enable   pipeline clock enable
//   pipe_reset    one-cycle synchronous pipeline clear
//   busy          high whenever the controller is not idle
//   mode          0 idle, 1 step, 2 continuous, 3 sending
// ---------------------------------------------------------------------------
module pipe_debug_controller #(
    parameter int          NUM_WORDS  = 16,
    parameter int          WORD_BYTES = 4,
    parameter logic [7:0]  CMD_STEP   = 8'h73,
    parameter logic [7:0]  CMD_CONT   = 8'h63,
    parameter logic [7:0]  CMD_RESET  = 8'h72
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_available,
    output logic                              rx_read,
    output logic [7:0]                        tx_data,
    output logic                              tx_write,
    input  logic                              tx_done,
    input  logic                              eop,
    input  logic [NUM_WORDS*WORD_BYTES*8-1:0] snapshot,
    output logic                              pipe_enable,
    output logic                              pipe_reset,
    output logic                              busy,
    output logic [1:0]                        mode
);

    localparam int NUM_BYTES = NUM_WORDS * WORD_BYTES;
    localparam int SNAP_W    = NUM_BYTES * 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_CONT = 2'd2;
    localparam logic [1:0] MODE_SEND = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POP,
        S_DECODE,
        S_STEP,
        S_CONT,
        S_RST,
        S_CAPTURE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SNAP_W-1:0]   capture_q, capture_d;
    logic [7:0]          txData_q, txData_d;
    logic                rxRead_q, rxRead_d;
    logic                txWrite_q, txWrite_d;
    logic                pipeEnable_q, pipeEnable_d;
    logic                pipeReset_q, pipeReset_d;
    logic                busy_q, busy_d;
    logic [1:0]          mode_q, mode_d;

    // Next-state and next-output logic. Every output is computed from the
    // state being entered, so the registered outputs line up exactly with
    // the state they describe. Strobes default low and are raised only on
    // the transition into the state that owns them.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_d    = capture_q;
        txData_d     = txData_q;
        rxRead_d     = 1'b0;
        txWrite_d    = 1'b0;
        pipeEnable_d = 1'b0;
        pipeReset_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_available) begin
                    state_d  = S_POP;
                    rxRead_d = 1'b1;
                end
            end
            S_POP: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Unknown bytes fall straight back to idle with no side effects.
                if (rx_data == CMD_STEP) begin
                    state_d      = S_STEP;
                    pipeEnable_d = 1'b1;
                end else if (rx_data == CMD_CONT) begin
                    state_d      = S_CONT;
                    pipeEnable_d = 1'b1;
                end else if (rx_data == CMD_RESET) begin
                    state_d     = S_RST;
                    pipeReset_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                state_d = S_CAPTURE;
            end
            S_CONT: begin
                // The enable stays up through the cycle in which eop is seen,
                // so an eop already high on entry still yields one enable cycle.
                if (eop) begin
                    state_d = S_CAPTURE;
                end else begin
                    pipeEnable_d = 1'b1;
                end
            end
            S_RST: begin
                state_d = S_IDLE;
            end
            S_CAPTURE: begin
                capture_d = snapshot;
                state_d   = S_SEND;
            end
            S_SEND: begin
                txData_d  = capture_q[{cnt_q, 3'b000} +: 8];
                txWrite_d = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Only one byte is ever in flight; the next push waits for tx_done.
                if (tx_done) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);

        case (state_d)
            S_STEP:                     mode_d = MODE_STEP;
            S_CONT:                     mode_d = MODE_CONT;
            S_CAPTURE, S_SEND, S_WAIT:  mode_d = MODE_SEND;
            default:                    mode_d = MODE_IDLE;
        endcase
    end

    // State, counter, capture register and all outputs. Reset abandons any
    // partial dump, so the next dump restarts from byte 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            capture_q    <= '0;
            txData_q     <= '0;
            rxRead_q     <= 1'b0;
            txWrite_q    <= 1'b0;
            pipeEnable_q <= 1'b0;
            pipeReset_q  <= 1'b0;
            busy_q       <= 1'b0;
            mode_q       <= MODE_IDLE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            capture_q    <= capture_d;
            txData_q     <= txData_d;
            rxRead_q     <= rxRead_d;
            txWrite_q    <= txWrite_d;
            pipeEnable_q <= pipeEnable_d;
            pipeReset_q  <= pipeReset_d;
            busy_q       <= busy_d;
            mode_q       <= mode_d;
        end
    end

    assign rx_read     = rxRead_q;
    assign tx_data     = txData_q;
    assign tx_write    = txWrite_q;
    assign pipe_enable = pipeEnable_q;
    assign pipe_reset  = pipeReset_q;
    assign busy        = busy_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_pipe_debug_controller.sv
// ---------------------------------------------------------------------------
// tb_pipe_debug_controller
//
// Bench for pipe_debug_controller with NUM_WORDS=2, WORD_BYTES=4. Provides a
// small RX FIFO, a TX responder that pulses tx_done a programmable number of
// cycles after each push, a procedural reference model of the command
// behaviour, a per-cycle compare process, directed scenarios and a random
// command loop.
// ---------------------------------------------------------------------------
module tb_pipe_debug_controller;

    localparam int NW = 2;
    localparam int WB = 4;
    localparam int NB = NW * WB;
    localparam int SW = NB * 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_available;
    logic          rx_read;
    logic [7:0]    tx_data;
    logic          tx_write;
    logic          tx_done = 1'b0;
    logic          eop = 1'b0;
    logic [SW-1:0] snapshot = 64'h11223344_55667788;
    logic          pipe_enable;
    logic          pipe_reset;
    logic          busy;
    logic [1:0]    mode;

    pipe_debug_controller #(
        .NUM_WORDS  (NW),
        .WORD_BYTES (WB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_available (rx_available),
        .rx_read      (rx_read),
        .tx_data      (tx_data),
        .tx_write     (tx_write),
        .tx_done      (tx_done),
        .eop          (eop),
        .snapshot     (snapshot),
        .pipe_enable  (pipe_enable),
        .pipe_reset   (pipe_reset),
        .busy         (busy),
        .mode         (mode)
    );

    // 10 time-unit clock period.
    always #5 clock = ~clock;

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic boundExpired(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // RX FIFO: the driver writes entries, the pop on rx_read presents the head
    // byte on rx_data for the following cycle.
    logic [7:0] rxMem [0:63];
    int         wrPtr = 0;
    int         rdPtr = 0;

    assign rx_available = (wrPtr != rdPtr);

    always @(posedge clock) begin
        if (rx_read && (rdPtr != wrPtr)) begin
            rx_data <= rxMem[rdPtr % 64];
            rdPtr   <= rdPtr + 1;
        end
    end

    task automatic pushByte(input logic [7:0] b);
        rxMem[wrPtr % 64] = b;
        wrPtr++;
    endtask

    // TX responder: acknowledges each pushed byte txDelay cycles later with a
    // one-cycle tx_done pulse.
    int txDelay   = 5;
    int respDelay = 0;
    int doneCount = 0;

    always begin
        @(negedge clock);
        if (tx_write && !reset) begin
            respDelay = txDelay;
            repeat (respDelay) @(negedge clock);
            tx_done = 1'b1;
            doneCount++;
            @(negedge clock);
            tx_done = 1'b0;
        end
    end

    // Activity monitor: running totals the directed scenarios use for their
    // hand-computed expectations.
    int         enHigh   = 0;
    int         enRuns   = 0;
    int         curRun   = 0;
    int         lastRun  = 0;
    int         rstHigh  = 0;
    int         writes   = 0;
    int         busyHigh = 0;
    logic       prevEn   = 1'b0;
    logic [7:0] txLog[$];

    always @(negedge clock) begin
        if (pipe_enable) begin
            if (!prevEn) begin
                enRuns++;
                curRun = 0;
            end
            curRun++;
            enHigh++;
        end else if (prevEn) begin
            lastRun = curRun;
        end
        prevEn = pipe_enable;
        if (pipe_reset) rstHigh++;
        if (tx_write) begin
            writes++;
            txLog.push_back(tx_data);
        end
        if (busy) busyHigh++;
    end

    // Reference model: walks through a command the way the behaviour reads,
    // one clock at a time, and publishes what each output must be for the
    // cycle that follows each edge. An asserted reset abandons the command.
    logic          mRead, mEnable, mReset, mWrite, mBusy;
    logic [1:0]    mMode;
    logic [7:0]    mData;
    logic [SW-1:0] mCaptured;

    task automatic zeroModel();
        mRead = 0; mEnable = 0; mReset = 0; mWrite = 0; mBusy = 0;
        mMode = 2'd0; mData = 8'h00; mCaptured = '0;
    endtask

    task automatic step(output bit ab);
        @(posedge clock or posedge reset);
        ab = reset;
    endtask

    task automatic modelDump(output bit ab);
        step(ab); if (ab) return;
        mCaptured = snapshot;
        for (int i = 0; i < NB; i++) begin
            step(ab); if (ab) return;
            mWrite = 1'b1;
            mData  = mCaptured[8*i +: 8];
            do begin
                step(ab); if (ab) return;
                mWrite = 1'b0;
            end while (!tx_done);
        end
        mBusy = 1'b0;
        mMode = 2'd0;
    endtask

    task automatic modelRun();
        bit         ab;
        logic [7:0] cmd;
        forever begin
            step(ab); if (ab) return;
            if (rx_available) begin
                mRead = 1'b1;
                mBusy = 1'b1;
                step(ab); if (ab) return;
                mRead = 1'b0;
                step(ab); if (ab) return;
                cmd = rx_data;
                if (cmd == 8'h73) begin
                    mEnable = 1'b1; mMode = 2'd1;
                    step(ab); if (ab) return;
                    mEnable = 1'b0; mMode = 2'd3;
                    modelDump(ab); if (ab) return;
                end else if (cmd == 8'h63) begin
                    mEnable = 1'b1; mMode = 2'd2;
                    do begin
                        step(ab); if (ab) return;
                    end while (!eop);
                    mEnable = 1'b0; mMode = 2'd3;
                    modelDump(ab); if (ab) return;
                end else if (cmd == 8'h72) begin
                    mReset = 1'b1;
                    step(ab); if (ab) return;
                    mReset = 1'b0;
                    mBusy  = 1'b0;
                end else begin
                    mBusy = 1'b0;
                end
            end
        end
    endtask

    initial begin
        zeroModel();
        forever begin
            wait (!reset);
            modelRun();
            zeroModel();
        end
    end

    // Compare process: every cycle, away from the active edge, the DUT
    // outputs must equal the model; tx_data only matters while pushed.
    always @(negedge clock) begin
        checkOutput("rx_read",     rx_read,     mRead);
        checkOutput("pipe_enable", pipe_enable, mEnable);
        checkOutput("pipe_reset",  pipe_reset,  mReset);
        checkOutput("tx_write",    tx_write,    mWrite);
        checkOutput("busy",        busy,        mBusy);
        checkOutput("mode",        mode,        mMode);
        if (mWrite) checkOutput("tx_data", tx_data, mData);
    end

    // Waits until the RX FIFO is drained and the controller is idle again.
    task automatic waitIdle();
        int lim;
        lim = 0;
        while (((rdPtr != wrPtr) || busy) && (lim < 3000)) begin
            @(negedge clock);
            lim++;
        end
        if (lim >= 3000) boundExpired("idle_timeout");
        @(negedge clock);
        #1;
    endtask

    // Issues one command; for a continuous run, raises eop eopDelay cycles
    // after the enable appears (or before the command when eopPre is set).
    task automatic applyStimulus(input logic [7:0] cmd, input int eopDelay, input bit eopPre);
        int lim;
        if (cmd == 8'h63 && eopPre) eop = 1'b1;
        pushByte(cmd);
        if (cmd == 8'h63) begin
            lim = 0;
            while (!pipe_enable && lim < 50) begin
                @(negedge clock);
                lim++;
            end
            if (lim >= 50) boundExpired("cont_start_timeout");
            if (!eopPre) begin
                repeat (eopDelay) @(negedge clock);
                eop = 1'b1;
            end
            lim = 0;
            while (pipe_enable && lim < 200) begin
                @(negedge clock);
                lim++;
            end
            if (lim >= 200) boundExpired("cont_stop_timeout");
            eop = 1'b0;
        end
        waitIdle();
    endtask

    task automatic checkDumpBytes(input string name, input int base, input logic [SW-1:0] value);
        for (int i = 0; i < NB; i++) begin
            if (base + i < txLog.size())
                checkOutput(name, txLog[base + i], value[8*i +: 8]);
            else
                boundExpired(name);
        end
    endtask

    // Watchdog so the bench always ends on its own.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by a random command loop.
    initial begin
        int         bEn, bRuns, bRst, bWr, bBusy, bLog, bDone, lim;
        logic [7:0] expBytes [0:7];
        logic [7:0] cmd;
        int         r;

        expBytes[0] = 8'h88; expBytes[1] = 8'h77; expBytes[2] = 8'h66; expBytes[3] = 8'h55;
        expBytes[4] = 8'h44; expBytes[5] = 8'h33; expBytes[6] = 8'h22; expBytes[7] = 8'h11;

        repeat (3) @(negedge clock);
        checkOutput("reset_rx_read",     rx_read,     1'b0);
        checkOutput("reset_tx_write",    tx_write,    1'b0);
        checkOutput("reset_tx_data",     tx_data,     8'h00);
        checkOutput("reset_pipe_enable", pipe_enable, 1'b0);
        checkOutput("reset_busy",        busy,        1'b0);
        checkOutput("reset_mode",        mode,        2'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;

        $display("[TB] step command with snapshot changed mid-dump");
        bEn = enHigh; bRuns = enRuns; bWr = writes; bLog = txLog.size();
        txDelay = 5;
        pushByte(8'h73);
        lim = 0;
        while ((writes == bWr) && lim < 100) begin
            @(negedge clock); #1; lim++;
        end
        if (lim >= 100) boundExpired("step_first_write_timeout");
        snapshot = {$urandom, $urandom};
        waitIdle();
        checkOutput("step_enable_cycles", enHigh - bEn, 1);
        checkOutput("step_enable_runs",   enRuns - bRuns, 1);
        checkOutput("step_writes",        writes - bWr, 8);
        for (int i = 0; i < 8; i++) checkOutput("step_byte", txLog[bLog + i], expBytes[i]);
        snapshot = 64'h11223344_55667788;

        $display("[TB] continuous run, eop ten cycles in");
        bWr = writes; bLog = txLog.size();
        applyStimulus(8'h63, 10, 1'b0);
        checkOutput("cont_run_length", lastRun, 11);
        checkOutput("cont_writes", writes - bWr, 8);
        checkDumpBytes("cont_byte", bLog, 64'h11223344_55667788);

        $display("[TB] continuous run with eop already high");
        applyStimulus(8'h63, 0, 1'b1);
        checkOutput("cont_eop_pre_length", lastRun, 1);

        $display("[TB] pipeline reset command");
        bEn = enHigh; bRst = rstHigh; bWr = writes; bBusy = busyHigh;
        applyStimulus(8'h72, 0, 1'b0);
        checkOutput("rst_pulses",      rstHigh - bRst, 1);
        checkOutput("rst_writes",      writes - bWr, 0);
        checkOutput("rst_enable",      enHigh - bEn, 0);
        checkOutput("rst_busy_cycles", busyHigh - bBusy, 3);

        $display("[TB] unknown byte then step");
        bRuns = enRuns; bRst = rstHigh; bWr = writes;
        pushByte(8'h41);
        pushByte(8'h73);
        waitIdle();
        checkOutput("junk_enable_runs", enRuns - bRuns, 1);
        checkOutput("junk_resets",      rstHigh - bRst, 0);
        checkOutput("junk_writes",      writes - bWr, 8);

        $display("[TB] tx_done held off for 100 cycles");
        bWr = writes;
        txDelay = 100;
        pushByte(8'h73);
        lim = 0;
        while ((writes == bWr) && lim < 100) begin
            @(negedge clock); #1; lim++;
        end
        if (lim >= 100) boundExpired("hold_first_write_timeout");
        repeat (2) @(negedge clock);
        txDelay = 5;
        repeat (60) @(negedge clock);
        #1;
        checkOutput("hold_single_write", writes - bWr, 1);
        waitIdle();
        checkOutput("hold_total_writes", writes - bWr, 8);

        $display("[TB] reset in the middle of a dump");
        bDone = doneCount;
        pushByte(8'h73);
        lim = 0;
        while ((doneCount - bDone < 3) && lim < 200) begin
            @(negedge clock); #1; lim++;
        end
        if (lim >= 200) boundExpired("midreset_done_timeout");
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset_busy",     busy,        1'b0);
        checkOutput("midreset_mode",     mode,        2'd0);
        checkOutput("midreset_tx_write", tx_write,    1'b0);
        checkOutput("midreset_tx_data",  tx_data,     8'h00);
        checkOutput("midreset_enable",   pipe_enable, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        bWr = writes; bLog = txLog.size();
        applyStimulus(8'h73, 0, 1'b0);
        checkOutput("midreset_writes", writes - bWr, 8);
        for (int i = 0; i < 8; i++) checkOutput("midreset_byte", txLog[bLog + i], expBytes[i]);

        $display("[TB] random commands");
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      cmd = 8'h73;
            else if (r == 1) cmd = 8'h63;
            else if (r == 2) cmd = 8'h72;
            else begin
                cmd = 8'($urandom_range(0, 255));
                while (cmd == 8'h73 || cmd == 8'h63 || cmd == 8'h72) cmd = 8'($urandom_range(0, 255));
            end
            txDelay  = $urandom_range(1, 8);
            snapshot = {$urandom, $urandom};
            applyStimulus(cmd, $urandom_range(0, 12), ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
